// File: rtl/jt51_sh_var.sv
// jt51_sh_var
// Clock-enabled delay line whose length is chosen at run time. Words are kept
// in a circular buffer of `stages` entries. The write pointer moves on every
// cen step, and the read pointer trails it by the registered length. For a
// non-power-of-2 `stages`, the read index is built by explicit modular
// arithmetic rather than by relying on pointer wrap-around.
//
// Parameters:
//   width  - data word width
//   stages - maximum delay in cen steps (2 <= stages <= 2**aw)
//   aw     - buffer pointer width
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   cen    in   clock enable, one delay step per enabled edge
//   clr    in   synchronous flush; takes priority over cen
//   len    in   requested delay in cen steps (clamped to 1..stages)
//   din    in   input word
//   drop   out  delayed word
//   primed out  drop holds valid delayed data
//
// Build option:
//   JT51_SH_ZERO_FILL_EN - when defined, drop reads as 0 while primed is low.

module jt51_sh_var #(
    parameter int width  = 5,
    parameter int stages = 32,
    parameter int aw     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             clr,
    input  logic [aw:0]      len,
    input  logic [width-1:0] din,
    output logic [width-1:0] drop,
    output logic             primed
);

    localparam logic [aw:0]   stages_l = (aw+1)'(stages);
    localparam logic [aw-1:0] last_wp  = aw'(stages - 1);

    logic [width-1:0] mem [stages];
    logic [aw-1:0]    wp;
    logic [aw:0]      fill;
    logic [aw:0]      len_r;
    logic [aw:0]      len_c;
    logic [aw:0]      wp_ext;
    logic [aw-1:0]    rp;
    logic [width-1:0] rd_word;

    // Out-of-range lengths are folded into 1..stages so that the read
    // pointer can never reach outside the buffer.
    always_comb begin
        len_c = len;
        if (len == '0)
            len_c = (aw+1)'(1);
        else if (len > stages_l)
            len_c = stages_l;
    end

    // Pointer, fill counter and registered length. A new length restarts
    // priming, and the write made on that same edge counts as the first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            fill  <= '0;
            len_r <= stages_l;
        end else if (clr) begin
            fill  <= '0;
            len_r <= len_c;
        end else if (cen) begin
            wp <= (wp == last_wp) ? '0 : wp + aw'(1);
            if (len_c != len_r) begin
                len_r <= len_c;
                fill  <= (aw+1)'(1);
            end else if (fill < stages_l) begin
                fill <= fill + (aw+1)'(1);
            end
        end
    end

    // The storage array has no reset, so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!clr && cen)
            mem[wp] <= din;
    end

    // The read index is (wp - len_r) mod stages. Because len_r <= stages,
    // one conditional add of stages is enough to bring it back into range.
    always_comb begin
        wp_ext = {1'b0, wp};
        if (wp_ext >= len_r)
            rp = aw'(wp_ext - len_r);
        else
            rp = aw'(wp_ext + stages_l - len_r);
        rd_word = mem[rp];
        primed  = (fill >= len_r);
    end

`ifdef JT51_SH_ZERO_FILL_EN
    assign drop = primed ? rd_word : '0;
`else
    assign drop = rd_word;
`endif

endmodule
